bypass_wb_arbiter: RTL and testbench
====================================

Name: bypass_wb_arbiter

Overview:
- Shares the single write-back port of the bypass buffer between NUM_REQ execution-unit requesters (e.g. ALU, MAC, load unit) using round-robin.
- Throttles grants on stall and buffer-full.
- Registers the winning index/data onto the bypass buffer's write-back inputs and tracks per-cycle arbitration state.
- Sits between the lane's execution units and the bypass buffer's write-back inputs.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8).
- WIDTH_IDX, 8, width of the write-back register index.
- WIDTH_DATA, 32, width of the write-back data.
- WIDTH_SCNT, 8, width of the saturating stall-cycle counter.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- I_Stall  in  1  force stall; no grant while 1.
- I_Full  in  1  bypass buffer full; no grant while 1.
- I_Req  in  NUM_REQ  per-requester request valid; held until acked.
- I_Index  in  NUM_REQ*WIDTH_IDX  per-requester destination index, packed, requester 0 in LSBs.
- I_Data  in  NUM_REQ*WIDTH_DATA  per-requester data, packed the same way.
- O_Ack  out  NUM_REQ  one-hot grant, combinational, same cycle as grant.
- O_WB_Valid  out  1  registered write-back valid (maps to dst valid bit).
- O_WB_Index  out  WIDTH_IDX  registered write-back index.
- O_WB_Data  out  WIDTH_DATA  registered write-back data.
- O_Grant_No  out  $clog2(NUM_REQ)  registered number of the last winner.
- O_Busy  out  1  1 when the FSM is not IDLE.
- O_Stall_Cnt  out  WIDTH_SCNT  saturating count of cycles spent in BLOCK.

Behaviour:
- Reset values: all outputs 0; internal Last_Grant = NUM_REQ-1, so requester 0 wins first; FSM = IDLE.
- Reset asserted mid-operation: all state clears immediately. The pending O_WB_Valid pulse is dropped. Requesters keep I_Req high and are re-arbitrated after reset release.
- Grant_En = ~I_Stall & ~I_Full & (|I_Req).
- Round-robin order: search starts at (Last_Grant+1) mod NUM_REQ and proceeds upward with wrap; the first requester with I_Req=1 wins.
  - O_Ack[win]=1 only when Grant_En.
  - On grant, Last_Grant <= win.
- Handshake:
  - A requester sees O_Ack=1, then may change or drop its request at the next edge.
  - With no ack, it must hold I_Req, I_Index and I_Data stable.
- Latency: grant in cycle N. In cycle N+1: O_WB_Valid=1, O_WB_Index/O_WB_Data = winner's values, O_Grant_No = win.
- O_WB_Valid is a single-cycle pulse per grant; maximum throughput is 1 write-back per cycle.
- Without a grant, O_WB_Valid <= 0; index/data hold their previous value.
- I_Stall or I_Full rising while an O_WB_Valid pulse is already registered: the pulse still issues (it was committed the previous cycle). The bypass buffer absorbs it.
- Same destination index from two requesters in one cycle: only the RR winner is granted; the other waits. No merging.
- FSM:
  - IDLE: no requests. |I_Req & Grant_En goes to RUN; |I_Req & ~Grant_En goes to BLOCK.
  - RUN: granting. Stays in RUN while Grant_En; goes to BLOCK on |I_Req & (I_Stall|I_Full); goes to IDLE when ~|I_Req.
  - BLOCK: requests pending but blocked. O_Stall_Cnt += 1 each cycle, saturating at all-ones. Goes to RUN when Grant_En; goes to IDLE when ~|I_Req.
  - O_Stall_Cnt clears only on reset.

Optional Feature:
- Macro: BYPASS_WB_AGE_PRIORITY_EN.
- Defined:
  - Each requester has a 4-bit wait counter. It increments each cycle the requester has I_Req=1 and is not acked, and clears on ack.
  - When any counter reaches 15, the lowest-numbered such requester wins regardless of the RR pointer. Last_Grant still updates to it.
- Undefined: pure round-robin; counters are absent.

Decomposition:
- pkg_tpu additions:
  - typedef wb_req_t {v, idx, data}.
  - constant NUM_WB_REQ = 3.
  - enum wb_arb_st_t {IDLE, RUN, BLOCK}.
- Sub-module wb_rr_pick: combinational rotate / priority-find / unrotate. Inputs are the request vector and Last_Grant; outputs are a one-hot vector plus the encoded winner and a found flag.
- Everything else lives in the top block.

Test Plan:
- Reset release, I_Req=3'b111 held for 6 cycles: acks 001,010,100,001,010,100; O_WB_Valid high cycles 2-7; O_Grant_No 0,1,2,0,1,2.
- I_Req=3'b010 with I_Index[1]=8'h2A, I_Data[1]=32'hDEADBEEF: ack cycle N; cycle N+1 O_WB_Valid=1, index 2A, data DEADBEEF; cycle N+2 O_WB_Valid=0.
- I_Req=3'b101, I_Full=1 for 4 cycles, then 0:
  - blocked window: no ack; FSM=BLOCK; O_Stall_Cnt=4.
  - after release: requester 0 granted first, then 2.
- I_Stall asserted in the same cycle as a prior grant's output: O_WB_Valid still pulses once; no new ack until I_Stall=0.
- reset driven low while in RUN with I_Req=3'b110: all outputs 0 immediately; after release, requester 1 granted first.
- With BYPASS_WB_AGE_PRIORITY_EN: requester 2 continuously requesting while 0/1 are favoured by the pointer; requester 2 is granted no later than 15 cycles after first request.

Source files
------------

// File: rtl/bypass_wb_arbiter_pkg.sv
// bypass_wb_arbiter_pkg: shared types and defaults for the bypass buffer write-back arbiter
package bypass_wb_arbiter_pkg;
    localparam int NUM_WB_REQ = 3;
    localparam int WB_IDX_W   = 8;
    localparam int WB_DATA_W  = 32;
    localparam int WB_SCNT_W  = 8;
    typedef enum logic [1:0] {IDLE, RUN, BLOCK} wb_arb_st_t;
    typedef struct packed {
        logic                 v;
        logic [WB_IDX_W-1:0]  idx;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/bypass_wb_arbiter_rr_pick.sv
// wb_rr_pick: combinational round-robin picker (rotate, find lowest, unrotate) starting after last
module wb_rr_pick
    import bypass_wb_arbiter_pkg::*;
#(
    parameter int N = NUM_WB_REQ,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] onehot,
    output logic [W-1:0] win,
    output logic         found
);
    localparam int         W1 = W + 1;
    localparam logic [W:0] NV = W1'(N);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W:0]     sh;
    logic [W:0]     off;
    logic [W:0]     sum;
    // bit 0 of rot is the requester just after last; the lowest set bit wins
    always_comb begin
        dbl = {req, req};
        sh  = {1'b0, last} + 1'b1;
        rot = N'(dbl >> sh);
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = W1'(k);
        end
        sum    = sh + off;
        win    = W'(sum >= NV ? sum - NV : sum);
        found  = |rot;
        onehot = found ? (N'(1) << win) : '0;
    end
endmodule

// File: rtl/bypass_wb_arbiter.sv
// bypass_wb_arbiter: round-robin share of the bypass write-back port; BYPASS_WB_AGE_PRIORITY_EN adds starvation aging
module bypass_wb_arbiter
    import bypass_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = NUM_WB_REQ,
    parameter int WIDTH_IDX  = WB_IDX_W,
    parameter int WIDTH_DATA = WB_DATA_W,
    parameter int WIDTH_SCNT = WB_SCNT_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          I_Stall,
    input  logic                          I_Full,
    input  logic [NUM_REQ-1:0]            I_Req,
    input  logic [NUM_REQ*WIDTH_IDX-1:0]  I_Index,
    input  logic [NUM_REQ*WIDTH_DATA-1:0] I_Data,
    output logic [NUM_REQ-1:0]            O_Ack,
    output logic                          O_WB_Valid,
    output logic [WIDTH_IDX-1:0]          O_WB_Index,
    output logic [WIDTH_DATA-1:0]         O_WB_Data,
    output logic [$clog2(NUM_REQ)-1:0]    O_Grant_No,
    output logic                          O_Busy,
    output logic [WIDTH_SCNT-1:0]         O_Stall_Cnt
);
    localparam int GW = $clog2(NUM_REQ);
    logic [WIDTH_IDX-1:0]  idx_a  [NUM_REQ];
    logic [WIDTH_DATA-1:0] data_a [NUM_REQ];
    wb_arb_st_t            state_q, state_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic [GW-1:0]         grant_no_q, grant_no_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [WIDTH_IDX-1:0]  wb_index_q, wb_index_d;
    logic [WIDTH_DATA-1:0] wb_data_q, wb_data_d;
    logic [WIDTH_SCNT-1:0] stall_cnt_q, stall_cnt_d;
    logic [NUM_REQ-1:0]    rr_hot, hot;
    logic [GW-1:0]         rr_win, win;
    logic                  rr_found, grant_en;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign idx_a[i]  = I_Index[i*WIDTH_IDX +: WIDTH_IDX];
        assign data_a[i] = I_Data[i*WIDTH_DATA +: WIDTH_DATA];
    end

    wb_rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
        .req    (I_Req),
        .last   (last_grant_q),
        .onehot (rr_hot),
        .win    (rr_win),
        .found  (rr_found)
    );

    // reset also masks the combinational ack so every output reads 0 while reset is held
    assign grant_en = reset & ~I_Stall & ~I_Full & rr_found;
    assign O_Ack    = grant_en ? hot : '0;

`ifdef BYPASS_WB_AGE_PRIORITY_EN
    logic [3:0]         age_q [NUM_REQ];
    logic [3:0]         age_d [NUM_REQ];
    logic [NUM_REQ-1:0] old;
    logic [GW-1:0]      age_win;
    // a requester whose wait counter saturated overrides the rotating pointer, lowest number first
    always_comb begin
        old     = '0;
        age_win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            old[k] = I_Req[k] & (age_q[k] == 4'hF);
            if (old[k]) age_win = GW'(k);
        end
        win = |old ? age_win : rr_win;
        hot = |old ? (NUM_REQ'(1) << age_win) : rr_hot;
    end
    // wait counters climb while a request sits unacked and clear on its ack
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            age_d[k] = O_Ack[k] ? 4'h0 : (I_Req[k] && age_q[k] != 4'hF) ? age_q[k] + 4'h1 : age_q[k];
        end
    end
    // wait counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_REQ; k++) age_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) age_q[k] <= age_d[k];
        end
    end
`else
    assign win = rr_win;
    assign hot = rr_hot;
`endif

    // next state: idle without requests, otherwise run when granting and block when throttled
    always_comb begin
        state_d = ~rr_found ? IDLE : (grant_en ? RUN : BLOCK);
    end

    // write-back staging: a grant loads the winner's index/data, otherwise they hold
    always_comb begin
        wb_valid_d   = grant_en;
        wb_index_d   = grant_en ? idx_a[win] : wb_index_q;
        wb_data_d    = grant_en ? data_a[win] : wb_data_q;
        grant_no_d   = grant_en ? win : grant_no_q;
        last_grant_d = grant_en ? win : last_grant_q;
        stall_cnt_d  = (state_q == BLOCK && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    // state registers; pointer resets to the top so requester 0 wins first
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_no_q   <= '0;
            wb_valid_q   <= 1'b0;
            wb_index_q   <= '0;
            wb_data_q    <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_no_q   <= grant_no_d;
            wb_valid_q   <= wb_valid_d;
            wb_index_q   <= wb_index_d;
            wb_data_q    <= wb_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign O_WB_Valid  = wb_valid_q;
    assign O_WB_Index  = wb_index_q;
    assign O_WB_Data   = wb_data_q;
    assign O_Grant_No  = grant_no_q;
    assign O_Busy      = state_q != IDLE;
    assign O_Stall_Cnt = stall_cnt_q;
endmodule

// File: tb/tb_bypass_wb_arbiter.sv
// tb_bypass_wb_arbiter: table-driven and directed checks of the write-back arbiter
module tb_bypass_wb_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        I_Stall = 1'b0;
    logic        I_Full = 1'b0;
    logic [2:0]  I_Req = '0;
    logic [23:0] I_Index;
    logic [95:0] I_Data;
    logic [2:0]  O_Ack;
    logic        O_WB_Valid;
    logic [7:0]  O_WB_Index;
    logic [31:0] O_WB_Data;
    logic [1:0]  O_Grant_No;
    logic        O_Busy;
    logic [7:0]  O_Stall_Cnt;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic       stall;
        logic       full;
        logic [2:0] req;
        logic [2:0] ack;
        logic       v;
        logic [1:0] gno;
        logic       busy;
        logic [7:0] scnt;
    } vec_t;
    vec_t tbl [20];

    bypass_wb_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .I_Stall     (I_Stall),
        .I_Full      (I_Full),
        .I_Req       (I_Req),
        .I_Index     (I_Index),
        .I_Data      (I_Data),
        .O_Ack       (O_Ack),
        .O_WB_Valid  (O_WB_Valid),
        .O_WB_Index  (O_WB_Index),
        .O_WB_Data   (O_WB_Data),
        .O_Grant_No  (O_Grant_No),
        .O_Busy      (O_Busy),
        .O_Stall_Cnt (O_Stall_Cnt)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(int s, int f, int r, int a, int v, int g, int b, int c);
        vec_t x;
        x.stall = 1'(s);
        x.full  = 1'(f);
        x.req   = 3'(r);
        x.ack   = 3'(a);
        x.v     = 1'(v);
        x.gno   = 2'(g);
        x.busy  = 1'(b);
        x.scnt  = 8'(c);
        return x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        I_Stall = 1'b0;
        I_Full  = 1'b0;
        I_Req   = '0;
        I_Index = {8'h12, 8'h11, 8'h10};
        I_Data  = {32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        // stall, full, req -> ack, wb_valid, grant_no, busy, stall_cnt
        tbl[0]  = mk(0, 0, 7, 1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 7, 2, 1, 0, 1, 0);
        tbl[2]  = mk(0, 0, 7, 4, 1, 1, 1, 0);
        tbl[3]  = mk(0, 0, 7, 1, 1, 2, 1, 0);
        tbl[4]  = mk(0, 0, 7, 2, 1, 0, 1, 0);
        tbl[5]  = mk(0, 0, 7, 4, 1, 1, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 1, 2, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 2, 0, 0);
        tbl[8]  = mk(1, 0, 3, 0, 0, 2, 0, 0);
        tbl[9]  = mk(0, 0, 3, 1, 0, 2, 1, 0);
        tbl[10] = mk(1, 0, 3, 0, 1, 0, 1, 1);
        tbl[11] = mk(1, 0, 3, 0, 0, 0, 1, 1);
        tbl[12] = mk(0, 0, 3, 2, 0, 0, 1, 2);
        tbl[13] = mk(0, 0, 1, 1, 1, 1, 1, 3);
        tbl[14] = mk(0, 0, 0, 0, 1, 0, 1, 3);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 3);
        tbl[16] = mk(0, 1, 4, 0, 0, 0, 0, 3);
        tbl[17] = mk(0, 0, 4, 4, 0, 0, 1, 3);
        tbl[18] = mk(0, 0, 0, 0, 1, 2, 1, 4);
        tbl[19] = mk(0, 0, 0, 0, 0, 2, 0, 4);

        #2 reset = 1'b0;
        I_Req = 3'b111;
        #1;
        chk("rst_ack", O_Ack, 3'b000);
        chk("rst_valid", O_WB_Valid, 1'b0);
        chk("rst_index", O_WB_Index, 8'h00);
        chk("rst_data", O_WB_Data, 32'h0);
        chk("rst_gno", O_Grant_No, 2'd0);
        chk("rst_busy", O_Busy, 1'b0);
        chk("rst_scnt", O_Stall_Cnt, 8'd0);

        do_reset();
        for (int k = 0; k < 20; k++) begin
            I_Stall = tbl[k].stall;
            I_Full  = tbl[k].full;
            I_Req   = tbl[k].req;
            #1;
            chk($sformatf("tbl%0d_ack", k), O_Ack, tbl[k].ack);
            chk($sformatf("tbl%0d_valid", k), O_WB_Valid, tbl[k].v);
            chk($sformatf("tbl%0d_gno", k), O_Grant_No, tbl[k].gno);
            chk($sformatf("tbl%0d_busy", k), O_Busy, tbl[k].busy);
            chk($sformatf("tbl%0d_scnt", k), O_Stall_Cnt, tbl[k].scnt);
            if (tbl[k].v) begin
                chk($sformatf("tbl%0d_index", k), O_WB_Index, 8'h10 + 8'(tbl[k].gno));
                chk($sformatf("tbl%0d_data", k), O_WB_Data, 32'hA5A5_0000 + 32'(tbl[k].gno));
            end
            @(negedge clock);
        end

        do_reset();
        I_Index[15:8] = 8'h2A;
        I_Data[63:32] = 32'hDEAD_BEEF;
        I_Req = 3'b010;
        #1 chk("single_ack", O_Ack, 3'b010);
        @(negedge clock);
        I_Req = 3'b000;
        #1;
        chk("single_valid", O_WB_Valid, 1'b1);
        chk("single_index", O_WB_Index, 8'h2A);
        chk("single_data", O_WB_Data, 32'hDEAD_BEEF);
        chk("single_gno", O_Grant_No, 2'd1);
        @(negedge clock);
        #1;
        chk("single_valid_drop", O_WB_Valid, 1'b0);
        chk("single_index_hold", O_WB_Index, 8'h2A);

        do_reset();
        I_Req  = 3'b101;
        I_Full = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 chk($sformatf("full%0d_ack", c), O_Ack, 3'b000);
            if (c > 0) chk($sformatf("full%0d_busy", c), O_Busy, 1'b1);
            @(negedge clock);
        end
        I_Full = 1'b0;
        #1 chk("full_rel_ack", O_Ack, 3'b001);
        @(negedge clock);
        I_Req = 3'b100;
        #1;
        chk("full_rel2_ack", O_Ack, 3'b100);
        chk("full_rel2_gno", O_Grant_No, 2'd0);
        @(negedge clock);
        I_Req = 3'b000;
        #1;
        chk("full_rel3_valid", O_WB_Valid, 1'b1);
        chk("full_rel3_gno", O_Grant_No, 2'd2);
        chk("full_scnt", O_Stall_Cnt, 8'd4);

        do_reset();
        I_Req = 3'b110;
        #1 chk("mid_ack1", O_Ack, 3'b010);
        @(negedge clock);
        #1;
        chk("mid_ack2", O_Ack, 3'b100);
        chk("mid_valid", O_WB_Valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_rst_ack", O_Ack, 3'b000);
        chk("mid_rst_valid", O_WB_Valid, 1'b0);
        chk("mid_rst_index", O_WB_Index, 8'h00);
        chk("mid_rst_data", O_WB_Data, 32'h0);
        chk("mid_rst_gno", O_Grant_No, 2'd0);
        chk("mid_rst_busy", O_Busy, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1 chk("mid_after_ack", O_Ack, 3'b010);
        @(negedge clock);
        #1 chk("mid_after_gno", O_Grant_No, 2'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
